// File: rtl/stat_update_scheduler_if.sv
// Update channel from the scheduler into the pet stats datapath.
// Valid/ready handshake; the payload is a target stat, a direction and a magnitude.
interface stat_update_scheduler_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [2:0] upd_stat;
  logic       upd_inc;
  logic [3:0] upd_amt;

  modport master (output upd_valid, upd_stat, upd_inc, upd_amt, input upd_ready);
  modport slave  (input upd_valid, upd_stat, upd_inc, upd_amt, output upd_ready);
endinterface

// File: rtl/stat_update_scheduler.sv
// Decay tick generation, button-to-request conversion and arbitration onto one update channel.
// Optional STAT_SCHED_DROPCNT_EN: count cooldown-dropped presses and merged ticks on drop_cnt_o.
//
// state   | meaning
// S_IDLE  | no job; picks pending decay first, then the highest-priority pending action
// S_DECAY | walks stats 0..4, subtracting DECAY_STEP from each
// S_ACT   | presents one action payload, then loads the cooldown
module stat_update_scheduler #(
  parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
  parameter logic [3:0]  COOLDOWN   = 4'd2,
  parameter logic [3:0]  DECAY_STEP = 4'd1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [4:0]                     act_req_i,
  stat_update_scheduler_if.master        upd,
  output logic                           tick_o,
  output logic                           busy_o,
  output logic [7:0]                     drop_cnt_o
);

  localparam int FEED  = 0;
  localparam int PLAY  = 1;
  localparam int CLEAN = 2;
  localparam int SLEEP = 3;
  localparam int HEAL  = 4;

  typedef enum logic [1:0] {S_IDLE, S_DECAY, S_ACT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [2:0]  stat_q, stat_d;
  logic        inc_q, inc_d;
  logic [3:0]  amt_q, amt_d;

  logic [23:0] cnt_q;
  logic        decay_pend_q;
  logic [4:0]  act_pend_q;
  logic [4:0]  act_req_q;
  logic [3:0]  cool_q;

  logic [4:0]  req_edge;
  logic [4:0]  pick;
  logic [4:0]  take_mask;
  logic        take_decay;
  logic        act_done;
  logic        xfer;

  assign tick_o   = (cnt_q == MAX_COUNT - 24'd1);
  assign req_edge = act_req_i & ~act_req_q;
  assign xfer     = valid_q & upd.upd_ready;
  assign busy_o   = (state_q != S_IDLE);

  assign upd.upd_valid = valid_q;
  assign upd.upd_stat  = stat_q;
  assign upd.upd_inc   = inc_q;
  assign upd.upd_amt   = amt_q;

  // Fixed action priority: heal > feed > sleep > clean > play.
  always_comb begin
    pick = '0;
    if (act_pend_q[HEAL])       pick[HEAL]  = 1'b1;
    else if (act_pend_q[FEED])  pick[FEED]  = 1'b1;
    else if (act_pend_q[SLEEP]) pick[SLEEP] = 1'b1;
    else if (act_pend_q[CLEAN]) pick[CLEAN] = 1'b1;
    else if (act_pend_q[PLAY])  pick[PLAY]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      stat_q  <= '0;
      inc_q   <= 1'b0;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      stat_q  <= stat_d;
      inc_q   <= inc_d;
      amt_q   <= amt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    take_decay = 1'b0;
    take_mask  = '0;
    act_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (decay_pend_q) begin
          state_d    = S_DECAY;
          idx_d      = '0;
          take_decay = 1'b1;
        end else if (|act_pend_q) begin
          state_d   = S_ACT;
          take_mask = pick;
        end
      end
      S_DECAY: begin
        if (xfer) begin
          if (idx_q == 3'd4) state_d = S_IDLE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_ACT: begin
        if (xfer) begin
          state_d  = S_IDLE;
          act_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    stat_d  = stat_q;
    inc_d   = inc_q;
    amt_d   = amt_q;
    if (take_decay) begin
      valid_d = 1'b1;
      stat_d  = 3'd0;
      inc_d   = 1'b0;
      amt_d   = DECAY_STEP;
    end else if (|take_mask) begin
      valid_d = 1'b1;
      inc_d   = 1'b1;
      if (take_mask[HEAL])       begin stat_d = 3'd2; amt_d = 4'd2; end
      else if (take_mask[FEED])  begin stat_d = 3'd0; amt_d = 4'd4; end
      else if (take_mask[SLEEP]) begin stat_d = 3'd4; amt_d = 4'd4; end
      else if (take_mask[CLEAN]) begin stat_d = 3'd3; amt_d = 4'd4; end
      else                       begin stat_d = 3'd1; amt_d = 4'd3; end
    end else if (state_d == S_IDLE) begin
      valid_d = 1'b0;
      stat_d  = '0;
      inc_d   = 1'b0;
      amt_d   = '0;
    end else if (state_q == S_DECAY) begin
      stat_d = idx_d;
    end
  end

  // Capture runs regardless of FSM state; cooldown load wins over a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      decay_pend_q <= 1'b0;
      act_pend_q   <= '0;
      act_req_q    <= '0;
      cool_q       <= '0;
    end else begin
      cnt_q        <= tick_o ? 24'd0 : cnt_q + 24'd1;
      act_req_q    <= act_req_i;
      decay_pend_q <= (decay_pend_q & ~take_decay) | tick_o;
      act_pend_q   <= (act_pend_q & ~take_mask) | ((cool_q == 4'd0) ? req_edge : 5'd0);
      if (act_done)                      cool_q <= COOLDOWN;
      else if (tick_o && cool_q != 4'd0) cool_q <= cool_q - 4'd1;
    end
  end

`ifdef STAT_SCHED_DROPCNT_EN
  logic [7:0] drop_cnt_q;
  logic [2:0] drops;
  logic [8:0] drop_sum;

  always_comb begin
    drops = {2'b00, tick_o & decay_pend_q & ~take_decay};
    if (cool_q != 4'd0) begin
      for (int i = 0; i < 5; i++) drops = drops + {2'b00, req_edge[i]};
    end
    drop_sum = {1'b0, drop_cnt_q} + {6'd0, drops};
  end

  always_ff @(posedge clk) begin
    if (reset)             drop_cnt_q <= '0;
    else if (drop_sum[8])  drop_cnt_q <= 8'd255;
    else                   drop_cnt_q <= drop_sum[7:0];
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_stat_update_scheduler.sv
// Scoreboard bench for stat_update_scheduler with MAX_COUNT=16, COOLDOWN=2, DECAY_STEP=1.
// Stimulus pushes expected payloads; the negedge monitor pops one per accepted transfer.
module tb_stat_update_scheduler;

`ifdef STAT_SCHED_DROPCNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] act_req = '0;
  logic       tick;
  logic       busy;
  logic [7:0] drop_cnt;

  stat_update_scheduler_if bus();

  stat_update_scheduler #(
    .MAX_COUNT (24'd16),
    .COOLDOWN  (4'd2),
    .DECAY_STEP(4'd1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .act_req_i (act_req),
    .upd       (bus),
    .tick_o    (tick),
    .busy_o    (busy),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay, exp_pay, prev_pay;
  logic       prev_stall = 1'b0;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int stat, int inc, int amt);
    logic [2:0] s;
    logic [3:0] a;
    s = stat[2:0];
    a = amt[3:0];
    exp_q.push_back({s, inc[0], a});
  endtask

  task automatic push_decay();
    for (int i = 0; i < 5; i++) push(i, 0, 1);
  endtask

  task automatic at_cycle(int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL at_cycle: got cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Scoreboard monitor and stall-stability check, sampled mid-cycle.
  always @(negedge clk) begin
    pay = {bus.upd_stat, bus.upd_inc, bus.upd_amt};
    if (prev_stall && bus.upd_valid) check("stall_stable", int'(pay), int'(prev_pay));
    prev_stall = bus.upd_valid && !bus.upd_ready && !reset;
    prev_pay   = pay;
    if (bus.upd_valid && bus.upd_ready && !reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got payload %h expected none (cycle %0d)", pay, cyc);
      end else begin
        exp_pay = exp_q.pop_front();
        check("xfer_payload", int'(pay), int'(exp_pay));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.upd_ready = 1'b0;

    // Idle decay, feed latency, cooldown drop, cooldown expiry
    do_reset();
    check("rst_valid", bus.upd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_stat", bus.upd_stat, 0);
    bus.upd_ready = 1'b1;
    push(0, 1, 4);
    push_decay();
    push_decay();
    push(0, 1, 4);
    at_cycle(3);  act_req = 5'b00001;
    at_cycle(4);  check("feed_lat_early", bus.upd_valid, 0);
    at_cycle(5);  check("feed_lat_valid", bus.upd_valid, 1);
                  check("feed_busy", busy, 1);
    at_cycle(7);  act_req = 5'b00000;
    at_cycle(9);  act_req = 5'b00001;
    at_cycle(11); act_req = 5'b00000;
                  check("feed_drop", drop_cnt, DROP_EN);
    at_cycle(14); check("tick_14", tick, 0);
    at_cycle(15); check("tick_15", tick, 1);
    at_cycle(16); check("tick_16", tick, 0);
    at_cycle(31); check("tick_31", tick, 1);
    at_cycle(40); act_req = 5'b00001;
    at_cycle(42); check("feed2_valid", bus.upd_valid, 1);
    at_cycle(44); act_req = 5'b00000;
    at_cycle(46); check("t1_drained", exp_q.size(), 0);
                  check("t1_drop", drop_cnt, DROP_EN);

    // heal and play together: heal first, play still served
    do_reset();
    bus.upd_ready = 1'b1;
    push(2, 1, 2);
    push(1, 1, 3);
    push_decay();
    at_cycle(2);  act_req = 5'b10010;
    at_cycle(4);  check("heal_stat", bus.upd_stat, 2);
    at_cycle(6);  check("play_stat", bus.upd_stat, 1);
                  check("play_valid", bus.upd_valid, 1);
    at_cycle(8);  act_req = 5'b00000;
    at_cycle(10); check("t2_drop", drop_cnt, 0);
    at_cycle(25); check("t2_drained", exp_q.size(), 0);

    // Stall at decay idx 2 for 40 cycles; ticks at 31 and 47 merge
    do_reset();
    bus.upd_ready = 1'b1;
    push_decay();
    push_decay();
    push_decay();
    at_cycle(19); bus.upd_ready = 1'b0;
                  check("stall_idx", bus.upd_stat, 2);
    at_cycle(40); check("stall_valid", bus.upd_valid, 1);
                  check("stall_stat", bus.upd_stat, 2);
    at_cycle(50); check("stall_drop", drop_cnt, DROP_EN);
    at_cycle(59); bus.upd_ready = 1'b1;
    at_cycle(75); check("t3_drained", exp_q.size(), 0);
                  check("t3_drop", drop_cnt, DROP_EN);

    // Tick and sleep edge in the same cycle
    do_reset();
    bus.upd_ready = 1'b1;
    push_decay();
    push(4, 1, 4);
    at_cycle(15); act_req = 5'b01000;
    at_cycle(17); act_req = 5'b00000;
                  check("tie_decay_first", bus.upd_stat, 0);
                  check("tie_decay_inc", bus.upd_inc, 0);
    at_cycle(23); check("tie_sleep_stat", bus.upd_stat, 4);
                  check("tie_sleep_inc", bus.upd_inc, 1);
    at_cycle(26); check("t4_drained", exp_q.size(), 0);

    // Reset while a job is presented and another is pending
    do_reset();
    bus.upd_ready = 1'b0;
    at_cycle(2);  act_req = 5'b00100;
    at_cycle(4);  check("clean_valid", bus.upd_valid, 1);
                  check("clean_stat", bus.upd_stat, 3);
    at_cycle(5);  act_req = 5'b00010;
    at_cycle(6);  reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", bus.upd_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_stat", bus.upd_stat, 0);
    check("midrst_amt", bus.upd_amt, 0);
    check("midrst_drop", drop_cnt, 0);
    act_req = 5'b00000;
    @(posedge clk);
    #1 reset = 1'b0;
    bus.upd_ready = 1'b1;
    at_cycle(12); check("no_replay_valid", bus.upd_valid, 0);
                  check("no_replay_busy", busy, 0);

    check("final_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
